// File: rtl/instruction_decode.sv
// instruction_decode
//   Decode stage of the 8-bit pipelined core. It returns the jump and
//   immediate-select controls to fetch in the same cycle, latches the
//   fetched instruction into IF/ID, reads the register file and loads the
//   ID/EX register that feeds execute. It also owns the register-file write
//   port, which write-back drives.
//
// Ports
//   Clk, Reset        clock; asynchronous active-high reset
//   Instruction_Code  instruction from fetch (current cycle)
//   Imm_Data          sign-extended immediate from fetch (current cycle)
//   PCSrc, ImmSel     combinational controls returned to fetch
//   RegWrite_WB, Write_Reg_WB, Write_Data_WB   register-file write port
//   *_EX              ID/EX pipeline register outputs toward execute
module instruction_decode #(
  parameter int NUM_REGS = 8,
  parameter int WIDTH    = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [7:0]       Instruction_Code,
  input  logic [WIDTH-1:0] Imm_Data,
  output logic             PCSrc,
  output logic             ImmSel,
  input  logic             RegWrite_WB,
  input  logic [2:0]       Write_Reg_WB,
  input  logic [WIDTH-1:0] Write_Data_WB,
  output logic             Valid_EX,
  output logic [1:0]       Opcode_EX,
  output logic [2:0]       Rd_EX,
  output logic [WIDTH-1:0] Read_Data1_EX,
  output logic [WIDTH-1:0] Read_Data2_EX,
  output logic [WIDTH-1:0] Imm_EX,
  output logic             RegWrite_EX,
  output logic             ALUSrc_EX
);

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_ADD = 2'b01,
    OP_LDI = 2'b10,
    OP_JMP = 2'b11
  } opcode_e;

  // Fetch-side controls: purely combinational so fetch can redirect the PC
  // in the same cycle, which is why no flush of IF/ID is ever needed.
  opcode_e fetch_op;
  assign fetch_op = opcode_e'(Instruction_Code[7:6]);
  assign PCSrc    = (fetch_op == OP_JMP);
  assign ImmSel   = (fetch_op == OP_JMP);

  // IF/ID latch
  logic [7:0]       ifid_instr_q, ifid_instr_d;
  logic [WIDTH-1:0] ifid_imm_q,   ifid_imm_d;
  logic             ifid_valid_q, ifid_valid_d;

  always_comb begin
    ifid_instr_d = Instruction_Code;
    ifid_imm_d   = Imm_Data;
    ifid_valid_d = 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ifid_instr_q <= '0;
      ifid_imm_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_imm_q   <= ifid_imm_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // Field extraction from the latched instruction
  opcode_e    id_op;
  logic [2:0] id_rd;
  logic [2:0] id_rs;
  assign id_op = opcode_e'(ifid_instr_q[7:6]);
  assign id_rd = ifid_instr_q[5:3];
  assign id_rs = ifid_instr_q[2:0];

  // Register file
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (RegWrite_WB) begin
      regs_d[Write_Reg_WB] = Write_Data_WB;
    end
  end

  // Reset is asynchronous, so a write-back arriving on the same edge that
  // Reset is asserted never lands.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports with write-through bypass: a register being written this
  // cycle returns the incoming value, so decode never sees stale data.
  logic [WIDTH-1:0] rd_data1;
  logic [WIDTH-1:0] rd_data2;

  always_comb begin
    rd_data1 = regs_q[id_rd];
    rd_data2 = regs_q[id_rs];
    if (RegWrite_WB && (Write_Reg_WB == id_rd)) begin
      rd_data1 = Write_Data_WB;
    end
    if (RegWrite_WB && (Write_Reg_WB == id_rs)) begin
      rd_data2 = Write_Data_WB;
    end
  end

  // Decoded controls
  logic id_regwrite;
  logic id_alusrc;

  always_comb begin
    id_regwrite = 1'b0;
    id_alusrc   = 1'b0;
    unique case (id_op)
      OP_MOV: id_regwrite = 1'b1;
      OP_ADD: id_regwrite = 1'b1;
      OP_LDI: begin
        id_regwrite = 1'b1;
        id_alusrc   = 1'b1;
      end
      OP_JMP: id_regwrite = 1'b0;
      default: id_regwrite = 1'b0;
    endcase
    // The cleared IF/ID content after reset decodes as MOV R0,R0; gating
    // with valid keeps that bubble from claiming a register write.
    if (!ifid_valid_q) begin
      id_regwrite = 1'b0;
    end
  end

  // ID/EX register
  logic             valid_ex_q,    valid_ex_d;
  logic [1:0]       opcode_ex_q,   opcode_ex_d;
  logic [2:0]       rd_ex_q,       rd_ex_d;
  logic [WIDTH-1:0] rdata1_ex_q,   rdata1_ex_d;
  logic [WIDTH-1:0] rdata2_ex_q,   rdata2_ex_d;
  logic [WIDTH-1:0] imm_ex_q,      imm_ex_d;
  logic             regwrite_ex_q, regwrite_ex_d;
  logic             alusrc_ex_q,   alusrc_ex_d;

  always_comb begin
    valid_ex_d    = ifid_valid_q;
    opcode_ex_d   = id_op;
    rd_ex_d       = id_rd;
    rdata1_ex_d   = rd_data1;
    rdata2_ex_d   = rd_data2;
    imm_ex_d      = ifid_imm_q;
    regwrite_ex_d = id_regwrite;
    alusrc_ex_d   = id_alusrc;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_ex_q    <= 1'b0;
      opcode_ex_q   <= '0;
      rd_ex_q       <= '0;
      rdata1_ex_q   <= '0;
      rdata2_ex_q   <= '0;
      imm_ex_q      <= '0;
      regwrite_ex_q <= 1'b0;
      alusrc_ex_q   <= 1'b0;
    end else begin
      valid_ex_q    <= valid_ex_d;
      opcode_ex_q   <= opcode_ex_d;
      rd_ex_q       <= rd_ex_d;
      rdata1_ex_q   <= rdata1_ex_d;
      rdata2_ex_q   <= rdata2_ex_d;
      imm_ex_q      <= imm_ex_d;
      regwrite_ex_q <= regwrite_ex_d;
      alusrc_ex_q   <= alusrc_ex_d;
    end
  end

  assign Valid_EX      = valid_ex_q;
  assign Opcode_EX     = opcode_ex_q;
  assign Rd_EX         = rd_ex_q;
  assign Read_Data1_EX = rdata1_ex_q;
  assign Read_Data2_EX = rdata2_ex_q;
  assign Imm_EX        = imm_ex_q;
  assign RegWrite_EX   = regwrite_ex_q;
  assign ALUSrc_EX     = alusrc_ex_q;

endmodule
